multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle variant of the RV32I core. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback. The FSM drives the PC, instruction-register and register-file write enables, the ALU operand and writeback mux selects, and the data-RAM strobes. It sits between the instruction register and the shared PC/ALU/RAM datapath, and it stalls on a data-memory ready handshake.

---
 rtl/control_pkg.sv | 90 +++++++++
 rtl/branch_resolver.sv | 23 ++
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle RV32I controller and its datapath:
// FSM states, opcode classes, opcode constants and mux-select encodings.
package control_pkg;

  // Controller states; the numeric encoding is what appears on STATE.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  // Instruction class captured in DECODE and used by later states.
  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I       = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } class_t;

  // RV32I major opcodes.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch FUNCT3 codes; 010 and 011 are not branches.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // PC_SRC: next-PC source.
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // ALU_SRC_A: first ALU operand.
  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_ZERO = 2'd1;
  localparam logic [1:0] SRCA_RS1  = 2'd2;

  // ALU_SRC_B: second ALU operand.
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // ALU_OP: request to ALU_CONTROL.
  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  // MEM_TO_REG: register-file write-data source.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Maps an opcode (and FUNCT3 for branches) to its instruction class.
  function automatic class_t classify(input logic [6:0] op, input logic [2:0] f3);
    class_t cls;
    case (op)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = (f3 == 3'b010 || f3 == 3'b011) ? CLS_ILLEGAL : CLS_BRANCH;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Combinational branch outcome from FUNCT3 and the ALU compare flags.
module branch_resolver
  import control_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_aluLsb,
  output logic       o_taken
);

  // BEQ/BNE use the zero flag; the ordered compares use the SLT/SLTU result bit.
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_taken = i_zero;
      F3_BNE:           o_taken = ~i_zero;
      F3_BLT, F3_BLTU:  o_taken = i_aluLsb;
      F3_BGE, F3_BGEU:  o_taken = ~i_aluLsb;
      default:          o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing controller: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
// Outputs decode from the state and the class latched in DECODE; only the branch
// PC_WRITE follows the ALU flags, and a store's RETIRE follows MEM_READY.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int STATE_W  = 3
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic [2:0]          FUNCT3,
  input  logic                ZERO,
  input  logic                ALU_LSB,
  input  logic                MEM_READY,
  output logic                IR_WRITE,
  output logic                PC_WRITE,
  output logic [1:0]          PC_SRC,
  output logic [1:0]          ALU_SRC_A,
  output logic [1:0]          ALU_SRC_B,
  output logic [1:0]          ALU_OP,
  output logic                MEM_READ,
  output logic                ENABLE_W,
  output logic [1:0]          MEM_TO_REG,
  output logic                REG_WRITE,
  output logic                RETIRE,
  output logic                ILLEGAL,
  output logic [STATE_W-1:0]  STATE
);

  state_t     r_state;
  class_t     r_class;
  logic [2:0] r_funct3;

  logic [6:0] w_opcode7;
  class_t     w_decClass;
  logic       w_taken;

  logic       w_irWrite;
  logic       w_pcWrite;
  logic [1:0] w_pcSrc;
  logic [1:0] w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [1:0] w_aluOp;
  logic       w_memRead;
  logic       w_enableW;
  logic [1:0] w_memToReg;
  logic       w_regWrite;
  logic       w_retire;
  logic       w_illegal;

  assign w_opcode7  = 7'(OPCODE);
  assign w_decClass = classify(w_opcode7, FUNCT3);

  branch_resolver u_branchResolver (
    .i_funct3 (r_funct3),
    .i_zero   (ZERO),
    .i_aluLsb (ALU_LSB),
    .o_taken  (w_taken)
  );

  // State register plus the class/FUNCT3 captured in DECODE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_FETCH;
      r_class  <= CLS_ILLEGAL;
      r_funct3 <= 3'b000;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_class  <= w_decClass;
          r_funct3 <= FUNCT3;
          r_state  <= (w_decClass == CLS_ILLEGAL) ? S_FETCH : S_EXECUTE;
        end
        S_EXECUTE: begin
          case (r_class)
            CLS_LOAD, CLS_STORE: r_state <= S_MEM;
            CLS_BRANCH:          r_state <= S_FETCH;
            default:             r_state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (MEM_READY) begin
            r_state <= (r_class == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Control decode for the current state; anything not set stays 0.
  always_comb begin
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_pcSrc    = PC_PLUS4;
    w_aluSrcA  = SRCA_PC;
    w_aluSrcB  = SRCB_RS2;
    w_aluOp    = ALUOP_ADD;
    w_memRead  = 1'b0;
    w_enableW  = 1'b0;
    w_memToReg = WB_ALU;
    w_regWrite = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irWrite = 1'b1;
        w_pcWrite = 1'b1;
        w_pcSrc   = PC_PLUS4;
        w_aluSrcA = SRCA_PC;
        w_aluSrcB = SRCB_FOUR;
        w_aluOp   = ALUOP_ADD;
      end
      S_DECODE: begin
        if (w_decClass == CLS_ILLEGAL) begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (r_class)
          CLS_R: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_RS2;
            w_aluOp   = ALUOP_FUNCT;
          end
          CLS_I: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_ADD;
          end
          CLS_LUI: begin
            w_aluSrcA = SRCA_ZERO;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_ADD;
          end
          CLS_AUIPC: begin
            w_aluSrcA = SRCA_PC;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_ADD;
          end
          CLS_BRANCH: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_RS2;
            w_aluOp   = ALUOP_BRANCH;
            w_pcSrc   = PC_IMM;
            w_pcWrite = w_taken;
            w_retire  = 1'b1;
          end
          CLS_JAL: begin
            w_pcWrite = 1'b1;
            w_pcSrc   = PC_IMM;
          end
          CLS_JALR: begin
            w_aluSrcA = SRCA_RS1;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_ADD;
            w_pcWrite = 1'b1;
            w_pcSrc   = PC_ALU;
          end
          default: begin
            w_pcWrite = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        if (r_class == CLS_LOAD) begin
          w_memRead = 1'b1;
        end else begin
          w_enableW = 1'b1;
          w_retire  = MEM_READY;
        end
      end
      S_WRITEBACK: begin
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
        if (r_class == CLS_LOAD) begin
          w_memToReg = WB_MEM;
        end else if (r_class == CLS_JAL || r_class == CLS_JALR) begin
          w_memToReg = WB_PC4;
        end else begin
          w_memToReg = WB_ALU;
        end
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  // Holding reset low silences every strobe at once, which also aborts a pending RAM access.
  assign IR_WRITE   = RESET_N & w_irWrite;
  assign PC_WRITE   = RESET_N & w_pcWrite;
  assign MEM_READ   = RESET_N & w_memRead;
  assign ENABLE_W   = RESET_N & w_enableW;
  assign REG_WRITE  = RESET_N & w_regWrite;
  assign RETIRE     = RESET_N & w_retire;
  assign ILLEGAL    = RESET_N & w_illegal;
  assign PC_SRC     = RESET_N ? w_pcSrc    : 2'd0;
  assign ALU_SRC_A  = RESET_N ? w_aluSrcA  : 2'd0;
  assign ALU_SRC_B  = RESET_N ? w_aluSrcB  : 2'd0;
  assign ALU_OP     = RESET_N ? w_aluOp    : 2'd0;
  assign MEM_TO_REG = RESET_N ? w_memToReg : 2'd0;
  assign STATE      = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle the full control vector is
// compared against a hand-written expected vector.
module tb_multicycle_control;

  logic       CLK;
  logic       RESET_N;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       ZERO;
  logic       ALU_LSB;
  logic       MEM_READY;
  logic       IR_WRITE;
  logic       PC_WRITE;
  logic [1:0] PC_SRC;
  logic [1:0] ALU_SRC_A;
  logic [1:0] ALU_SRC_B;
  logic [1:0] ALU_OP;
  logic       MEM_READ;
  logic       ENABLE_W;
  logic [1:0] MEM_TO_REG;
  logic       REG_WRITE;
  logic       RETIRE;
  logic       ILLEGAL;
  logic [2:0] STATE;

  int checkCount;
  int errorCount;

  multicycle_control dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .OPCODE     (OPCODE),
    .FUNCT3     (FUNCT3),
    .ZERO       (ZERO),
    .ALU_LSB    (ALU_LSB),
    .MEM_READY  (MEM_READY),
    .IR_WRITE   (IR_WRITE),
    .PC_WRITE   (PC_WRITE),
    .PC_SRC     (PC_SRC),
    .ALU_SRC_A  (ALU_SRC_A),
    .ALU_SRC_B  (ALU_SRC_B),
    .ALU_OP     (ALU_OP),
    .MEM_READ   (MEM_READ),
    .ENABLE_W   (ENABLE_W),
    .MEM_TO_REG (MEM_TO_REG),
    .REG_WRITE  (REG_WRITE),
    .RETIRE     (RETIRE),
    .ILLEGAL    (ILLEGAL),
    .STATE      (STATE)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [19:0] outVec;
  assign outVec = {IR_WRITE, PC_WRITE, PC_SRC, ALU_SRC_A, ALU_SRC_B, ALU_OP,
                   MEM_READ, ENABLE_W, MEM_TO_REG, REG_WRITE, RETIRE, ILLEGAL, STATE};

  // Expected control vector, packed in the same field order as outVec.
  function automatic logic [19:0] vec(input logic ir, input logic pcw, input logic [1:0] pcs,
                                      input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                      input logic mr, input logic ew, input logic [1:0] mtr,
                                      input logic rw, input logic ret, input logic ill,
                                      input logic [2:0] st);
    return {ir, pcw, pcs, a, b, op, mr, ew, mtr, rw, ret, ill, st};
  endfunction

  localparam logic [19:0] V_IDLE   = 20'h0;
  localparam logic [2:0]  ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4;

  task automatic checkOutput(input string tag, input logic [19:0] observed, input logic [19:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %05h expected %05h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                               input logic lsb, input logic rdy);
    OPCODE    = opc;
    FUNCT3    = f3;
    ZERO      = z;
    ALU_LSB   = lsb;
    MEM_READY = rdy;
  endtask

  // Drive inputs mid-cycle, check the settled outputs, then advance one clock.
  task automatic runCycle(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic z, input logic lsb, input logic rdy, input logic [19:0] expected);
    applyStimulus(opc, f3, z, lsb, rdy);
    #1;
    checkOutput(tag, outVec, expected);
    @(posedge CLK);
    #2;
  endtask

  logic [19:0] fetchV, decodeV;

  initial begin
    checkCount = 0;
    errorCount = 0;
    fetchV  = vec(1, 1, 2'd0, 2'd0, 2'd2, 2'd0, 0, 0, 2'd0, 0, 0, 0, ST_F);
    decodeV = vec(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 0, ST_D);

    RESET_N = 1'b0;
    applyStimulus(7'h33, 3'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("reset_async", outVec, V_IDLE);
    @(posedge CLK);
    #2;
    checkOutput("reset_held", outVec, V_IDLE);
    RESET_N = 1'b1;

    // add x3,x1,x2 with MEM_READY held low to show it is ignored outside MEM
    runCycle("add_F",  7'h33, 3'd0, 0, 0, 0, fetchV);
    runCycle("add_D",  7'h33, 3'd0, 0, 0, 0, decodeV);
    runCycle("add_E",  7'h33, 3'd0, 0, 0, 0, vec(0,0,2'd0,2'd2,2'd0,2'd2,0,0,2'd0,0,0,0,ST_E));
    runCycle("add_WB", 7'h33, 3'd0, 0, 0, 0, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,1,1,0,ST_W));

    // lw x5,8(x1) with two wait cycles: 7 cycles total
    runCycle("lw_F",   7'h03, 3'd2, 0, 0, 1, fetchV);
    runCycle("lw_D",   7'h03, 3'd2, 0, 0, 1, decodeV);
    runCycle("lw_E",   7'h03, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd2,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("lw_M0",  7'h03, 3'd2, 0, 0, 0, vec(0,0,2'd0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0,ST_M));
    runCycle("lw_M1",  7'h03, 3'd2, 0, 0, 0, vec(0,0,2'd0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0,ST_M));
    runCycle("lw_M2",  7'h03, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,1,0,2'd0,0,0,0,ST_M));
    runCycle("lw_WB",  7'h03, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd1,1,1,0,ST_W));

    // beq taken / not taken, then other branch flavours: 3 cycles each
    runCycle("beqT_F", 7'h63, 3'd0, 1, 0, 1, fetchV);
    runCycle("beqT_D", 7'h63, 3'd0, 1, 0, 1, decodeV);
    runCycle("beqT_E", 7'h63, 3'd0, 1, 0, 1, vec(0,1,2'd1,2'd2,2'd0,2'd1,0,0,2'd0,0,1,0,ST_E));
    runCycle("beqN_F", 7'h63, 3'd0, 0, 0, 1, fetchV);
    runCycle("beqN_D", 7'h63, 3'd0, 0, 0, 1, decodeV);
    runCycle("beqN_E", 7'h63, 3'd0, 0, 0, 1, vec(0,0,2'd1,2'd2,2'd0,2'd1,0,0,2'd0,0,1,0,ST_E));
    runCycle("bne_F",  7'h63, 3'd1, 1, 0, 1, fetchV);
    runCycle("bne_D",  7'h63, 3'd1, 1, 0, 1, decodeV);
    runCycle("bneN_E", 7'h63, 3'd1, 1, 0, 1, vec(0,0,2'd1,2'd2,2'd0,2'd1,0,0,2'd0,0,1,0,ST_E));
    runCycle("bltu_F", 7'h63, 3'd6, 0, 1, 1, fetchV);
    runCycle("bltu_D", 7'h63, 3'd6, 0, 1, 1, decodeV);
    runCycle("bltuT_E",7'h63, 3'd6, 0, 1, 1, vec(0,1,2'd1,2'd2,2'd0,2'd1,0,0,2'd0,0,1,0,ST_E));
    runCycle("bge_F",  7'h63, 3'd5, 0, 1, 1, fetchV);
    runCycle("bge_D",  7'h63, 3'd5, 0, 1, 1, decodeV);
    runCycle("bgeN_E", 7'h63, 3'd5, 0, 1, 1, vec(0,0,2'd1,2'd2,2'd0,2'd1,0,0,2'd0,0,1,0,ST_E));

    // jalr x1,0(x2)
    runCycle("jalr_F", 7'h67, 3'd0, 0, 0, 1, fetchV);
    runCycle("jalr_D", 7'h67, 3'd0, 0, 0, 1, decodeV);
    runCycle("jalr_E", 7'h67, 3'd0, 0, 0, 1, vec(0,1,2'd2,2'd2,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("jalr_WB",7'h67, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd2,1,1,0,ST_W));

    // jal, lui, auipc, addi execute-stage selects
    runCycle("jal_F",  7'h6F, 3'd0, 0, 0, 1, fetchV);
    runCycle("jal_D",  7'h6F, 3'd0, 0, 0, 1, decodeV);
    runCycle("jal_E",  7'h6F, 3'd0, 0, 0, 1, vec(0,1,2'd1,2'd0,2'd0,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("jal_WB", 7'h6F, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd2,1,1,0,ST_W));
    runCycle("lui_F",  7'h37, 3'd0, 0, 0, 1, fetchV);
    runCycle("lui_D",  7'h37, 3'd0, 0, 0, 1, decodeV);
    runCycle("lui_E",  7'h37, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd1,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("lui_WB", 7'h37, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,1,1,0,ST_W));
    runCycle("auipc_F",7'h17, 3'd0, 0, 0, 1, fetchV);
    runCycle("auipc_D",7'h17, 3'd0, 0, 0, 1, decodeV);
    runCycle("auipc_E",7'h17, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("auipc_W",7'h17, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,1,1,0,ST_W));
    runCycle("addi_F", 7'h13, 3'd0, 0, 0, 1, fetchV);
    runCycle("addi_D", 7'h13, 3'd0, 0, 0, 1, decodeV);
    runCycle("addi_E", 7'h13, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd2,2'd1,2'd2,0,0,2'd0,0,0,0,ST_E));
    runCycle("addi_WB",7'h13, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,1,1,0,ST_W));

    // illegal opcode 0x7F and illegal branch FUNCT3 010: skipped in DECODE
    runCycle("ill_F",  7'h7F, 3'd0, 0, 0, 1, fetchV);
    runCycle("ill_D",  7'h7F, 3'd0, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,0,1,1,ST_D));
    runCycle("illb_F", 7'h63, 3'd2, 0, 0, 1, fetchV);
    runCycle("illb_D", 7'h63, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0,0,1,1,ST_D));

    // sw completing normally: 4 cycles, RETIRE in MEM with MEM_READY=1
    runCycle("sw_F",   7'h23, 3'd2, 0, 0, 1, fetchV);
    runCycle("sw_D",   7'h23, 3'd2, 0, 0, 1, decodeV);
    runCycle("sw_E",   7'h23, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd2,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    runCycle("sw_M",   7'h23, 3'd2, 0, 0, 1, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,1,2'd0,0,1,0,ST_M));

    // sw aborted by reset while waiting in MEM
    runCycle("swr_F",  7'h23, 3'd2, 0, 0, 0, fetchV);
    runCycle("swr_D",  7'h23, 3'd2, 0, 0, 0, decodeV);
    runCycle("swr_E",  7'h23, 3'd2, 0, 0, 0, vec(0,0,2'd0,2'd2,2'd1,2'd0,0,0,2'd0,0,0,0,ST_E));
    applyStimulus(7'h23, 3'd2, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("swr_Mwait", outVec, vec(0,0,2'd0,2'd0,2'd0,2'd0,0,1,2'd0,0,0,0,ST_M));
    RESET_N = 1'b0;
    #1;
    checkOutput("swr_abort", outVec, V_IDLE);
    @(posedge CLK);
    #2;
    checkOutput("swr_held", outVec, V_IDLE);
    RESET_N = 1'b1;
    runCycle("swr_relF", 7'h33, 3'd0, 0, 0, 0, fetchV);
    runCycle("swr_relD", 7'h33, 3'd0, 0, 0, 0, decodeV);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
